// File: rtl/cfg_frame_loader.sv
// Serial config-frame loader: shifts {addr,data} frames LSB-first, queues valid ones, drains them as timed register writes.
// Build option: define CFG_PARITY_EN to append an odd-parity bit at the frame MSB.
module cfg_frame_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 4,
  parameter int WR_PULSE = 1,
  parameter int GAP_CYC  = 1
) (
  input  logic                     iTck,
  input  logic                     iTrst,
  input  logic                     iShiftEn,
  input  logic                     iTdi,
  input  logic                     iUpdate,
  input  logic                     iClrErr,
  input  logic                     iStall,
  output logic                     oWrEn,
  output logic [ADDR_W-1:0]        oRegAddr,
  output logic [DATA_W-1:0]        oData,
  output logic [$clog2(DEPTH):0]   oLevel,
  output logic                     oFull,
  output logic                     oEmpty,
  output logic                     oOvf,
  output logic                     oFrameErr,
  output logic                     oParErr,
  output logic [1:0]               oDbgState
);

  localparam int PW = ADDR_W + DATA_W;
`ifdef CFG_PARITY_EN
  localparam int FW = PW + 1;
`else
  localparam int FW = PW;
`endif
  localparam int CNT_W = $clog2(FW + 2);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMR_W = $clog2(WR_PULSE + GAP_CYC + 1) + 1;

  localparam logic [CNT_W-1:0] CNT_FRAME  = CNT_W'(FW);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(FW + 1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(WR_PULSE - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = (GAP_CYC > 0) ? TMR_W'(GAP_CYC - 1) : '0;
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, GAP = 2'd2} drainState_t;

  logic [FW-1:0]    sr;
  logic [CNT_W-1:0] bitCnt;
  logic             lenOk;
  logic             parOk;
  logic             push;
  logic             pop;

  logic [PW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [LVL_W-1:0] level;
  logic [PW-1:0]    popWord;

  drainState_t      state;
  drainState_t      stateNxt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmrNxt;
  logic             wrEnNxt;
  logic             availQ;

  // Update takes priority over a shift in the same cycle; sr keeps its contents.
  always_ff @(posedge iTck or posedge iTrst) begin
    if (iTrst) begin
      sr     <= '0;
      bitCnt <= '0;
    end else if (iUpdate) begin
      bitCnt <= '0;
    end else if (iShiftEn) begin
      sr <= {iTdi, sr[FW-1:1]};
      if (bitCnt != CNT_SAT) bitCnt <= bitCnt + 1'b1;
    end
  end

  assign lenOk = (bitCnt == CNT_FRAME);
`ifdef CFG_PARITY_EN
  assign parOk = ^sr;
`else
  assign parOk = 1'b1;
`endif
  assign push = iUpdate && lenOk && parOk && !oFull;

  always_ff @(posedge iTck) begin
    if (push) mem[wrPtr] <= sr[PW-1:0];
  end

  always_ff @(posedge iTck or posedge iTrst) begin
    if (iTrst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign oLevel  = level;
  assign oFull   = (level == LVL_FULL);
  assign oEmpty  = (level == '0);
  assign popWord = mem[rdPtr];

  // Error flags are sticky; a new error in the same cycle beats a clear.
  always_ff @(posedge iTck or posedge iTrst) begin
    if (iTrst) begin
      oOvf      <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      if (iUpdate && lenOk && parOk && oFull) oOvf <= 1'b1;
      else if (iClrErr)                       oOvf <= 1'b0;
      if (iUpdate && !lenOk) oFrameErr <= 1'b1;
      else if (iClrErr)      oFrameErr <= 1'b0;
    end
  end

`ifdef CFG_PARITY_EN
  always_ff @(posedge iTck or posedge iTrst) begin
    if (iTrst)                          oParErr <= 1'b0;
    else if (iUpdate && lenOk && !parOk) oParErr <= 1'b1;
    else if (iClrErr)                   oParErr <= 1'b0;
  end
`else
  assign oParErr = 1'b0;
`endif

  // availQ makes a freshly pushed entry sit one full cycle before it may be popped.
  always_comb begin
    stateNxt = state;
    tmrNxt   = tmr;
    wrEnNxt  = oWrEn;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!oEmpty && availQ && !iStall) begin
          pop      = 1'b1;
          wrEnNxt  = 1'b1;
          tmrNxt   = '0;
          stateNxt = STROBE;
        end
      end
      STROBE: begin
        if (tmr == PULSE_LAST) begin
          wrEnNxt  = 1'b0;
          tmrNxt   = '0;
          stateNxt = (GAP_CYC > 0) ? GAP : IDLE;
        end else begin
          tmrNxt = tmr + 1'b1;
        end
      end
      GAP: begin
        if (tmr == GAP_LAST) begin
          tmrNxt   = '0;
          stateNxt = IDLE;
        end else begin
          tmrNxt = tmr + 1'b1;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iTck or posedge iTrst) begin
    if (iTrst) begin
      state    <= IDLE;
      tmr      <= '0;
      oWrEn    <= 1'b0;
      oRegAddr <= '0;
      oData    <= '0;
      availQ   <= 1'b0;
    end else begin
      state  <= stateNxt;
      tmr    <= tmrNxt;
      oWrEn  <= wrEnNxt;
      availQ <= !oEmpty;
      if (pop) begin
        oRegAddr <= popWord[PW-1:DATA_W];
        oData    <= popWord[DATA_W-1:0];
      end
    end
  end

  assign oDbgState = state;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Bench for cfg_frame_loader: vector table, hand-written corner sequences and randomized rounds vs a queue model.
// Build option: define CFG_PARITY_EN to exercise the parity frame format.
module tb_cfg_frame_loader;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int DEPTH    = 4;
  localparam int WR_PULSE = 1;
  localparam int GAP_CYC  = 1;
  localparam int PW       = ADDR_W + DATA_W;
`ifdef CFG_PARITY_EN
  localparam int FW = PW + 1;
`else
  localparam int FW = PW;
`endif
  localparam int PERIOD = WR_PULSE + GAP_CYC + 1;
  localparam int LW     = $clog2(DEPTH) + 1;

  // clock / reset
  logic iTck = 1'b0;
  logic iTrst, iShiftEn, iTdi, iUpdate, iClrErr, iStall;
  always #5 iTck = ~iTck;

  logic              oWrEn, oFull, oEmpty, oOvf, oFrameErr, oParErr;
  logic [ADDR_W-1:0] oRegAddr;
  logic [DATA_W-1:0] oData;
  logic [LW-1:0]     oLevel;
  logic [1:0]        oDbgState;

  logic              bWrEn, bFull, bEmpty, bOvf, bFrameErr, bParErr;
  logic [ADDR_W-1:0] bRegAddr;
  logic [DATA_W-1:0] bData;
  logic [LW-1:0]     bLevel;
  logic [1:0]        bDbgState;

  cfg_frame_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                     .WR_PULSE(WR_PULSE), .GAP_CYC(GAP_CYC)) dut (
    .iTck(iTck), .iTrst(iTrst), .iShiftEn(iShiftEn), .iTdi(iTdi), .iUpdate(iUpdate),
    .iClrErr(iClrErr), .iStall(iStall), .oWrEn(oWrEn), .oRegAddr(oRegAddr), .oData(oData),
    .oLevel(oLevel), .oFull(oFull), .oEmpty(oEmpty), .oOvf(oOvf), .oFrameErr(oFrameErr),
    .oParErr(oParErr), .oDbgState(oDbgState)
  );

  cfg_frame_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                     .WR_PULSE(3), .GAP_CYC(0)) dutB (
    .iTck(iTck), .iTrst(iTrst), .iShiftEn(iShiftEn), .iTdi(iTdi), .iUpdate(iUpdate),
    .iClrErr(iClrErr), .iStall(iStall), .oWrEn(bWrEn), .oRegAddr(bRegAddr), .oData(bData),
    .oLevel(bLevel), .oFull(bFull), .oEmpty(bEmpty), .oOvf(bOvf), .oFrameErr(bFrameErr),
    .oParErr(bParErr), .oDbgState(bDbgState)
  );

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [PW-1:0] exp_q[$];
  int m_level;
  bit m_ovf, m_ferr, m_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [FW-1:0] mk_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic [PW-1:0] p;
    p = {a, d};
`ifdef CFG_PARITY_EN
    return {~^p, p};
`else
    return p;
`endif
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge iTck);
    #1;
  endtask

  task automatic do_reset();
    iTrst = 1'b1; iShiftEn = 1'b0; iTdi = 1'b0; iUpdate = 1'b0; iClrErr = 1'b0; iStall = 1'b0;
    tick(); tick();
    iTrst = 1'b0;
    m_level = 0; m_ovf = 0; m_ferr = 0; m_perr = 0;
    exp_q.delete();
  endtask

  task automatic shift_bits(input int n, input logic [31:0] v);
    for (int i = 0; i < n; i++) begin
      iShiftEn = 1'b1;
      iTdi = v[i];
      tick();
    end
    iShiftEn = 1'b0;
  endtask

  task automatic update_pulse(input bit clr);
    iUpdate = 1'b1; iClrErr = clr;
    tick();
    iUpdate = 1'b0; iClrErr = 1'b0;
  endtask

  task automatic clear_flags();
    iClrErr = 1'b1;
    tick();
    iClrErr = 1'b0;
    m_ovf = 0; m_ferr = 0; m_perr = 0;
  endtask

  // Reference model: outcome of one update from the frame rules, then drive and compare status.
  task automatic model_frame(input int nbits, input logic [31:0] v);
    int cnt;
    cnt = (nbits > FW) ? FW + 1 : nbits;
    if (cnt != FW) m_ferr = 1;
`ifdef CFG_PARITY_EN
    else if ($countones(v[FW-1:0]) % 2 == 0) m_perr = 1;
`endif
    else if (m_level == DEPTH) m_ovf = 1;
    else begin
      exp_q.push_back(v[PW-1:0]);
      m_level++;
    end
    shift_bits(nbits, v);
    update_pulse(0);
    chk("m_level", oLevel, m_level);
    chk("m_full", oFull, m_level == DEPTH);
    chk("m_empty", oEmpty, m_level == 0);
    chk("m_ovf", oOvf, m_ovf);
    chk("m_ferr", oFrameErr, m_ferr);
    chk("m_perr", oParErr, m_perr);
  endtask

  // Release stall and expect every queued frame as a strobe, in order, PERIOD cycles apart.
  task automatic drain_check();
    int cyc, prev, waited, highs;
    logic [PW-1:0] e;
    cyc = 0; prev = -1;
    iStall = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      waited = 0;
      do begin
        tick(); cyc++; waited++;
      end while (!oWrEn && waited < 20);
      chk("strobe_seen", oWrEn, 1);
      chk("strobe_word", {oRegAddr, oData}, e);
      if (prev >= 0) chk("strobe_period", cyc - prev, PERIOD);
      prev = cyc;
      tick(); cyc++;
      chk("strobe_width", oWrEn, 0);
    end
    m_level = 0;
    highs = 0;
    for (int i = 0; i < PERIOD + 3; i++) begin
      tick();
      if (oWrEn) highs++;
    end
    chk("no_extra_strobe", highs, 0);
    chk("drained_level", oLevel, 0);
    chk("drained_empty", oEmpty, 1);
  endtask

  typedef struct {
    int                dlen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                exp_wr;
    bit                exp_ferr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] fr;
    logic [6:0]  pat;
    int waited, highs, nupd, kind, nb;

    tbl[0] = '{0,  3'h5, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{-1, 3'h5, 8'hA5, 1'b0, 1'b1};
    tbl[2] = '{1,  3'h2, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{0,  3'h0, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{0,  3'h7, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{16, 3'h3, 8'h12, 1'b0, 1'b1};
    tbl[6] = '{0,  3'h3, 8'h12, 1'b1, 1'b0};

    // reset values, sampled while reset is held
    iTrst = 1'b1; iShiftEn = 1'b0; iTdi = 1'b0; iUpdate = 1'b0; iClrErr = 1'b0; iStall = 1'b0;
    #2;
    chk("rst_wr", oWrEn, 0);
    chk("rst_addr", oRegAddr, 0);
    chk("rst_data", oData, 0);
    chk("rst_level", oLevel, 0);
    chk("rst_empty", oEmpty, 1);
    chk("rst_full", oFull, 0);
    chk("rst_flags", {oOvf, oFrameErr, oParErr}, 0);
    do_reset();

    // table-driven single frames: strobe exactly at E+2 for one cycle
    for (int t = 0; t < 7; t++) begin
      fr = 32'(mk_frame(tbl[t].addr, tbl[t].data));
      shift_bits(FW + tbl[t].dlen, fr);
      update_pulse(0);
      chk("tbl_ferr", oFrameErr, tbl[t].exp_ferr);
      chk("tbl_level_e", oLevel, tbl[t].exp_wr ? 1 : 0);
      tick();
      chk("tbl_wr_e1", oWrEn, 0);
      tick();
      chk("tbl_wr_e2", oWrEn, tbl[t].exp_wr);
      chk("tbl_level_e2", oLevel, 0);
      if (tbl[t].exp_wr) begin
        chk("tbl_addr", oRegAddr, tbl[t].addr);
        chk("tbl_data", oData, tbl[t].data);
      end
      tick();
      chk("tbl_wr_e3", oWrEn, 0);
      tick(); tick();
      if (tbl[t].exp_ferr) begin
        clear_flags();
        chk("tbl_ferr_clr", oFrameErr, 0);
      end
    end

    // shift and update in the same cycle: the shift is dropped, so the frame is short
    fr = 32'(mk_frame(3'h1, 8'h11));
    shift_bits(FW - 1, fr);
    iShiftEn = 1'b1; iTdi = fr[FW-1];
    update_pulse(0);
    iShiftEn = 1'b0;
    chk("upd_wins_ferr", oFrameErr, 1);
    tick(); tick(); tick();
    chk("upd_wins_level", oLevel, 0);
    chk("upd_wins_nowr", oWrEn, 0);
    // error set beats a clear in the same cycle
    shift_bits(FW - 2, fr);
    update_pulse(1);
    chk("set_beats_clr", oFrameErr, 1);
    clear_flags();
    chk("clr_after", oFrameErr, 0);

    // overflow under stall: 4 fill, 5th dropped, then ordered drain
    do_reset();
    iStall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      model_frame(FW, 32'(mk_frame(3'(i + 1), 8'(8'h10 * i + 3))));
      if (i == 3) chk("ovf_full_after4", oFull, 1);
    end
    chk("ovf_flag", oOvf, 1);
    chk("ovf_level", oLevel, DEPTH);
    drain_check();

    // reset in the middle of a strobe flushes everything
    do_reset();
    iStall = 1'b1;
    model_frame(FW, 32'(mk_frame(3'h6, 8'h5E)));
    model_frame(FW, 32'(mk_frame(3'h1, 8'hC3)));
    iStall = 1'b0;
    waited = 0;
    do begin
      tick(); waited++;
    end while (!oWrEn && waited < 20);
    chk("pre_rst_wr", oWrEn, 1);
    iTrst = 1'b1;
    #1;
    chk("mid_rst_wr", oWrEn, 0);
    chk("mid_rst_empty", oEmpty, 1);
    chk("mid_rst_level", oLevel, 0);
    tick();
    iTrst = 1'b0;
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (oWrEn) highs++;
    end
    chk("post_rst_nowr", highs, 0);

    // WR_PULSE=3, GAP_CYC=0 instance: high 3, low 1, high 3
    do_reset();
    iStall = 1'b1;
    model_frame(FW, 32'(mk_frame(3'h4, 8'h81)));
    model_frame(FW, 32'(mk_frame(3'h2, 8'h7E)));
    iStall = 1'b0;
    waited = 0;
    do begin
      tick(); waited++;
    end while (!bWrEn && waited < 20);
    chk("b_first_word", {bRegAddr, bData}, {3'h4, 8'h81});
    for (int i = 0; i < 7; i++) begin
      pat[6 - i] = bWrEn;
      tick();
    end
    chk("b_pattern", pat, 7'b1110111);
    chk("b_second_word", {bRegAddr, bData}, {3'h2, 8'h7E});

`ifdef CFG_PARITY_EN
    // even-parity frame rejected, odd-parity frame goes through
    do_reset();
    fr = 32'(mk_frame(3'h4, 8'h66)) ^ (32'h1 << (FW - 1));
    shift_bits(FW, fr);
    update_pulse(0);
    chk("par_err", oParErr, 1);
    chk("par_level", oLevel, 0);
    chk("par_noferr", oFrameErr, 0);
    tick(); tick(); tick();
    chk("par_nowr", oWrEn, 0);
    fr = 32'(mk_frame(3'h4, 8'h66));
    shift_bits(FW, fr);
    update_pulse(0);
    tick(); tick();
    chk("par_ok_wr", oWrEn, 1);
    chk("par_ok_word", {oRegAddr, oData}, {3'h4, 8'h66});
    tick(); tick(); tick();
`endif

    // randomized rounds against the queue model
    do_reset();
    for (int r = 0; r < 10; r++) begin
      clear_flags();
      iStall = 1'b1;
      nupd = $urandom_range(1, 7);
      for (int u = 0; u < nupd; u++) begin
        kind = $urandom_range(0, 9);
        case (kind)
          0:       nb = FW - 1;
          1:       nb = FW + 1;
          2:       nb = FW + 2;
          3:       nb = $urandom_range(0, FW - 2);
          default: nb = FW;
        endcase
        fr = $urandom();
`ifdef CFG_PARITY_EN
        if ($urandom_range(0, 3) != 0) fr = 32'(mk_frame(fr[PW-1:DATA_W], fr[DATA_W-1:0]));
`endif
        model_frame(nb, fr);
      end
      drain_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cfg_frame_loader.md
Name: cfg_frame_loader

Overview:
Parametrised successor to the fixed 8-bit JTAG-TDO capture/FIFO/config-passer chain that programs the FIR filter registers. Shifts serial configuration frames {address, data} LSB-first and validates the bit count on each update strobe. Buffers valid frames in an internal FIFO and drains them as timed register-write strobes (oWrEn/oRegAddr/oData) to the filter coefficient/control registers. Synchronous single-clock design replaces the negedge latch; adds frame-length checking, overflow/error flags, stall and configurable strobe timing.

Parameters:
DATA_W, 8, data field width (bits)
ADDR_W, 3, register address field width (bits)
DEPTH, 4, FIFO depth in frames; power of two, >=2
WR_PULSE, 1, oWrEn high time in cycles, >=1
GAP_CYC, 1, idle cycles after each strobe, >=0

Ports:
iTck  in  1  clock; all logic on rising edge
iTrst  in  1  reset, asynchronous, active-high
iShiftEn  in  1  shift enable; iTdi sampled when high
iTdi  in  1  serial frame bit, LSB first
iUpdate  in  1  commit strobe: validate and push shifted frame
iClrErr  in  1  clears sticky error flags
iStall  in  1  holds drain FSM in IDLE (no new pops)
oWrEn  out  1  register write strobe
oRegAddr  out  ADDR_W  write address
oData  out  DATA_W  write data
oLevel  out  clog2(DEPTH)+1  FIFO occupancy
oFull  out  1  oLevel==DEPTH
oEmpty  out  1  oLevel==0
oOvf  out  1  sticky: valid frame dropped, FIFO full
oFrameErr  out  1  sticky: update with wrong bit count
oParErr  out  1  sticky parity error (0 without CFG_PARITY_EN)

Behaviour:
- FW = ADDR_W+DATA_W (+1 with CFG_PARITY_EN). Shift reg sr[FW-1:0]: on iShiftEn, sr <= {iTdi, sr[FW-1:1]}; bit counter saturates at FW+1.
- After FW shifts: sr[DATA_W-1:0]=data, sr[DATA_W+ADDR_W-1:DATA_W]=addr; parity bit (if present) at MSB.
- Edge with iUpdate=1: shift that cycle ignored (update wins); counter cleared; sr retained.
  - count!=FW -> oFrameErr<=1, no push.
  - count==FW, FIFO full (pre-pop state) -> oOvf<=1, dropped, even if pop in same cycle.
  - otherwise push; entry visible next cycle.
- FIFO: circular, binary pointers wrap at DEPTH; push+pop same cycle -> oLevel unchanged.
- Drain FSM states IDLE, STROBE, GAP:
  - IDLE: if !oEmpty && !iStall -> pop, load oRegAddr/oData, oWrEn<=1, go STROBE.
  - STROBE: hold WR_PULSE cycles, then oWrEn<=0; go GAP (GAP_CYC>0) or IDLE.
  - GAP: GAP_CYC cycles, then IDLE.
  - oRegAddr/oData hold last value until next pop.
  - iStall does not abort STROBE/GAP.
- Latency: idle, empty FIFO -> oWrEn high from edge E+2, E = edge sampling iUpdate. Back-to-back period WR_PULSE+GAP_CYC+1 cycles.
- Sticky flags: set wins over iClrErr in same cycle.
- Reset (any time, incl. mid-strobe): asynchronously oWrEn=0, oRegAddr=0, oData=0, oLevel=0, oEmpty=1, oFull=0, all flags 0, sr=0, counter 0, FSM IDLE, FIFO flushed.

Optional Feature:
CFG_PARITY_EN: frame gains MSB odd-parity bit (XOR of all FW bits must be 1). Mismatch on otherwise valid-length update -> oParErr<=1, frame dropped, no oOvf check. Without macro: FW=ADDR_W+DATA_W, no check, oParErr tied 0.

Test Plan:
Defaults; shift 11 bits of 0x5A5, pulse iUpdate at edge E -> oWrEn=1 only in cycle after E+2, oRegAddr=3'h5, oData=8'hA5, oLevel back to 0.
Shift 10 bits, iUpdate -> oFrameErr=1, oWrEn stays 0, oLevel=0; iClrErr -> oFrameErr=0.
iStall=1, push 5 valid frames -> oFull=1 after 4th, 5th sets oOvf=1, oLevel=4; release iStall -> 4 strobes in push order, 3 cycles apart.
Reset during oWrEn high -> oWrEn=0 immediately, oEmpty=1, oLevel=0; no strobe after release.
CFG_PARITY_EN, FW=12: frame with even bit count -> oParErr=1, no strobe; odd-parity frame -> normal strobe.
WR_PULSE=3, GAP_CYC=0, two queued frames -> oWrEn high 3 cycles, low 1, high 3.
